axis_frame_scheduler: RTL
=========================

Name: axis_frame_scheduler

Overview:
- Round-robin scheduler that shares one AXI-Stream output among NUM_CH hydrophone channel buffers.
- Each buffer is a first-word-fall-through FIFO that flags when a full frame is buffered.
- The block grants one channel at a time and streams exactly FRAME_LEN samples from it, with TLAST on the final beat and the channel ID on TUSER.
- It enforces a programmable inter-frame gap and sits between the per-channel sample buffers and the PS-side DMA stream port.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, width of channel ID; must equal ceil(log2(NUM_CH))
DATA_W, 32, sample width in bits
FRAME_LEN, 64, beats per frame (2..1024)
GAP_CYCLES, 2, idle cycles after each frame before next arbitration (0 = none)

Ports:
clk  in  1  system clock
reset_b  in  1  asynchronous active-low reset
enable  in  1  allows new grants; does not abort a frame in progress
ch_frame_ready  in  NUM_CH  bit i high = channel i holds >= FRAME_LEN samples
ch_valid  in  NUM_CH  bit i high = FWFT head of channel i valid
ch_data  in  NUM_CH*DATA_W  FWFT head data; channel i occupies bits [i*DATA_W +: DATA_W]
ch_pop  out  NUM_CH  one-hot pop strobe to the granted FIFO
m_axis_tdata  out  DATA_W  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  final beat of frame
m_axis_tuser  out  CH_W  ID of the channel being sent
frame_active  out  1  high while in SEND
frame_done  out  1  one-cycle pulse, registered, the cycle after the last handshake
frames_sent  out  16  total completed frames, wraps 0xFFFF -> 0

Behaviour:
- Reset (async, reset_b low): state IDLE, grant=0, rr_ptr=0, beat_cnt=0, gap_cnt=0, frames_sent=0, frame_done=0. Combinational outputs are forced by state: tvalid=0, tlast=0, ch_pop=0, frame_active=0, tuser=0.
- Reset mid-frame: frame is abandoned with no completion pulse; restarts cleanly from IDLE.
- State IDLE:
  - If enable && |ch_frame_ready: register grant = first set bit of ch_frame_ready searching rr_ptr, rr_ptr+1, ... modulo NUM_CH; clear beat_cnt; go to SEND.
  - Otherwise stay in IDLE.
- State SEND:
  - tvalid = ch_valid[grant]; tdata = ch_data[grant]; tuser = grant; tlast = (beat_cnt == FRAME_LEN-1) && tvalid.
  - Handshake = tvalid && tready. On handshake: ch_pop[grant]=1 (same cycle, combinational) and beat_cnt++.
  - Backpressure (tready=0): tdata is held stable because the FWFT head does not pop.
  - Underflow (ch_valid[grant]=0 mid-frame): tvalid drops and beat_cnt holds; resume on refill. No timeout.
  - Changes in ch_frame_ready after grant, including of the granted channel, are ignored.
  - On the last-beat handshake: frame_done=1 next cycle, frames_sent++, rr_ptr = grant+1 mod NUM_CH, beat_cnt=0.
  - Then go to GAP with gap_cnt = GAP_CYCLES-1 if GAP_CYCLES>0; otherwise go to IDLE.
- State GAP: outputs idle; decrement gap_cnt; at 0 go to IDLE.
- Latency: frame_ready sampled high in IDLE at cycle N -> tvalid may be high at N+1.
  - Minimum frame-to-frame spacing: FRAME_LEN + GAP_CYCLES + 1 cycles.
- enable deasserted in SEND or GAP: the current frame and gap complete; no new grant until enable is high.
- ch_pop is never asserted outside SEND or for a non-granted channel. At most one bit is set.
- Simultaneous requests: strict round-robin from rr_ptr. No channel waits more than NUM_CH-1 frames.
- Unused state encodings recover to IDLE with all outputs idle.

Test Plan:
- Single frame:
  - Stimulus: ch_frame_ready=0001, FIFO preloaded with 0..63, tready=1.
  - Required: 64 beats of 0..63, tuser=0, tlast only on beat 63, frame_done pulses once, frames_sent=1, then 2 idle gap cycles.
- Round-robin:
  - Stimulus: all four channels ready continuously, rr_ptr=0.
  - Required: tuser order 0,1,2,3,0. After channel 2 is served, with channels 1 and 3 ready, next grant is 3.
- Backpressure:
  - Stimulus: tready toggles 1,0,0,1 per cycle during a frame.
  - Required: tdata stable while tready=0, one pop per handshake, exactly 64 pops and 64 handshakes.
- Underflow:
  - Stimulus: ch_valid[grant] low for 5 cycles at beat 20.
  - Required: tvalid low for those 5 cycles, beat_cnt holds at 20, frame completes with tlast at beat 63.
- Enable low / reset mid-frame:
  - Stimulus: enable low at beat 10.
  - Required: frame finishes, no new grant until enable returns.
  - Stimulus: reset_b pulsed low at beat 30.
  - Required: all outputs 0 immediately, frames_sent=0, next grant is from channel 0.
- Counter wrap:
  - Stimulus: frames_sent forced to 0xFFFF, then one more frame completes.
  - Required: frames_sent reads 0x0000 and frame_done pulses.

Source files
------------

// File: rtl/axis_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_scheduler_if
// Brief    : AXI-Stream bundle carrying framed samples plus channel ID on TUSER.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_frame_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [CH_W-1:0]   tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_scheduler
// Brief    : Round-robin frame scheduler sharing one AXI-Stream output among
//            NUM_CH FWFT channel buffers, FRAME_LEN beats per grant, with a
//            programmable idle gap after each frame.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int DATA_W     = 32,
  parameter int FRAME_LEN  = 64,
  parameter int GAP_CYCLES = 2
) (
  input  wire logic                     clk,
  input  wire logic                     reset_b,
  input  wire logic                     enable,
  input  wire logic [NUM_CH-1:0]        ch_frame_ready,
  input  wire logic [NUM_CH-1:0]        ch_valid,
  input  wire logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic      [NUM_CH-1:0]        ch_pop,
  axis_frame_scheduler_if.master        m_axis,
  output logic                          frame_active,
  output logic                          frame_done,
  output logic      [15:0]              frames_sent
);

  localparam int BEAT_W = $clog2(FRAME_LEN);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CH_W:0]     NUM_CH_E  = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CH_W-1:0]   grant_q;
  logic [CH_W-1:0]   rr_q;
  logic [BEAT_W-1:0] beat_q;
  logic [GAP_W-1:0]  gap_q;
  logic [15:0]       frames_sent_q;
  logic              done_q;

  // Per-channel FWFT head data, unpacked for indexing by the grant.
  logic [DATA_W-1:0] w_data [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_data[g] = ch_data[g*DATA_W +: DATA_W];
  end

  // Requests rotated so bit 0 corresponds to the channel at rr_q.
  logic [NUM_CH-1:0] w_rot;
  assign w_rot = NUM_CH'({ch_frame_ready, ch_frame_ready} >> rr_q);

  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_pick;
  // Round-robin pick: lowest rotated request wins, then undo the rotation.
  always_comb begin
    w_sum = {1'b0, rr_q};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_sum = {1'b0, rr_q} + (CH_W+1)'(i);
      end
    end
    w_pick = (w_sum >= NUM_CH_E) ? CH_W'(w_sum - NUM_CH_E) : CH_W'(w_sum);
  end

  logic            w_send;
  logic            w_tvalid;
  logic            w_hs;
  logic            w_last;
  logic [CH_W-1:0] w_rr_next;

  assign w_send    = (state_q == S_SEND);
  assign w_tvalid  = w_send & ch_valid[grant_q];
  assign w_hs      = w_tvalid & m_axis.tready;
  assign w_last    = (beat_q == LAST_BEAT);
  assign w_rr_next = (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);

  // Stream outputs are decoded from the registered state so every non-SEND
  // state, including unused encodings, presents an idle bus.
  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tdata  = w_send ? w_data[grant_q] : '0;
  assign m_axis.tuser  = w_send ? grant_q : '0;
  assign m_axis.tlast  = w_tvalid & w_last;
  assign ch_pop        = w_hs ? (NUM_CH'(1) << grant_q) : '0;
  assign frame_active  = w_send;
  assign frame_done    = done_q;
  assign frames_sent   = frames_sent_q;

  // Scheduler FSM: arbitrate in IDLE, stream one frame in SEND, idle in GAP.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      beat_q        <= '0;
      gap_q         <= '0;
      frames_sent_q <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && (|ch_frame_ready)) begin
            grant_q <= w_pick;
            beat_q  <= '0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (w_last) begin
              done_q        <= 1'b1;
              frames_sent_q <= frames_sent_q + 16'd1;
              rr_q          <= w_rr_next;
              beat_q        <= '0;
              if (GAP_CYCLES > 0) begin
                gap_q   <= GAP_LOAD;
                state_q <= S_GAP;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
